// File: rtl/ext_bus_ctrl.sv
// rtl/ext_bus_ctrl.sv - multiplexed P0/P2 external bus controller for the 8051 core
module ext_bus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ALE,
  input  logic        req,
  input  logic [1:0]  kind,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  input  logic [7:0]  p0_in,
  output logic [7:0]  p2_out,
  output logic        PSEN_n,
  output logic        RD_n,
  output logic        WR_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ADDR = 2'd2,
    S_STRB = 2'd3
  } state_t;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  state_t      state;
  logic        ale_d;
  logic [2:0]  slot;
  logic [1:0]  job_kind;
  logic [15:0] job_addr;
  logic [7:0]  job_wdata;

  logic        rise;
  logic [15:0] start_addr;
  logic [1:0]  req_kind;

  // A rise is the first ALE-high cycle; ale_d resets high so a pulse already
  // in progress at reset release is not mistaken for a rise.
  assign rise = ALE & ~ale_d;

  // When a request is accepted on a rise in IDLE the captured registers are
  // not loaded yet, so the address phase takes the live bus address.
  assign start_addr = (state == S_IDLE) ? addr : job_addr;

  // Kind 3 is an alias for a code fetch.
  assign req_kind = (kind == 2'd3) ? K_FETCH : kind;

  // Bus cycle sequencer: capture, wait for ALE rise, address phase, strobe phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ale_d     <= 1'b1;
      slot      <= 3'd0;
      job_kind  <= K_FETCH;
      job_addr  <= 16'h0000;
      job_wdata <= 8'h00;
      ready     <= 1'b1;
      done      <= 1'b0;
      rdata     <= 8'h00;
      p0_out    <= 8'hFF;
      p0_oe     <= 1'b0;
      p2_out    <= 8'hFF;
      PSEN_n    <= 1'b1;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
    end else begin
      ale_d <= ALE;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            job_addr  <= addr;
            job_wdata <= wdata;
            job_kind  <= req_kind;
            ready     <= 1'b0;
            if (rise) begin
              state  <= S_ADDR;
              slot   <= 3'd0;
              p0_out <= start_addr[7:0];
              p0_oe  <= 1'b1;
              p2_out <= start_addr[15:8];
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rise) begin
            state  <= S_ADDR;
            slot   <= 3'd0;
            p0_out <= start_addr[7:0];
            p0_oe  <= 1'b1;
            p2_out <= start_addr[15:8];
          end
        end
        S_ADDR: begin
          if (slot == 3'd1) begin
            state  <= S_STRB;
            slot   <= 3'd0;
            PSEN_n <= ~(job_kind == K_FETCH);
            RD_n   <= ~(job_kind == K_READ);
            WR_n   <= ~(job_kind == K_WRITE);
            if (job_kind == K_WRITE) begin
              p0_out <= job_wdata;
              p0_oe  <= 1'b1;
            end else begin
              p0_oe  <= 1'b0;
            end
          end else begin
            slot <= slot + 3'd1;
          end
        end
        S_STRB: begin
          if (slot == 3'd2) begin
            state  <= S_IDLE;
            slot   <= 3'd0;
            ready  <= 1'b1;
            done   <= 1'b1;
            PSEN_n <= 1'b1;
            RD_n   <= 1'b1;
            WR_n   <= 1'b1;
            p0_oe  <= 1'b0;
            if (job_kind != K_WRITE) begin
              rdata <= p0_in;
            end
          end else begin
            slot <= slot + 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
